// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port round-robin arbiter/sequencer for a single-ported 64-bit data memory
//
// Purpose:
//   Grants one of two requesters (A = core load/store, B = debug/DMA loader)
//   at a time, drives the memory for exactly one ACCESS cycle, then returns
//   the result with a one-cycle acknowledge in RESP. Misaligned or
//   out-of-range addresses skip ACCESS and are acknowledged with err = 1.
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata   port A command (held until a_ack)
//   a_ack/a_rdata/a_err         port A response (rdata/err valid with ack, else 0)
//   b_*                         port B, same as port A
//   mem_addr/mem_wdata          memory address and store data (0 outside ACCESS)
//   mem_write/mem_read          memory strobes (high only during ACCESS)
//   mem_rdata                   memory load data, combinational from mem_addr
//   busy                        high whenever the sequencer is not IDLE

module data_mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Highest legal doubleword address, compared over the full address width
  // so large addresses fault instead of wrapping.
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DEPTH - 8);

  state_t            state;
  state_t            state_next;

  // Tie-break pointer: 0 = A wins the next tie, 1 = B wins.
  logic              ptr;

  // Latched command of the current winner.
  logic              cmd_port;   // 0 = A, 1 = B
  logic              cmd_we;
  logic              cmd_fault;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [DATA_W-1:0] resp_data;

  // Arbitration of the requests sampled in IDLE.
  logic              any_req;
  logic              tie;
  logic              win_b;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              win_fault;

  always_comb begin
    any_req   = a_req | b_req;
    tie       = a_req & b_req;
    win_b     = b_req & (~a_req | ptr);
    win_we    = win_b ? b_we    : a_we;
    win_addr  = win_b ? b_addr  : a_addr;
    win_wdata = win_b ? b_wdata : a_wdata;
    win_fault = (win_addr[2:0] != 3'b000) || (win_addr > MAX_ADDR);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_next = state;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    a_ack      = 1'b0;
    a_rdata    = '0;
    a_err      = 1'b0;
    b_ack      = 1'b0;
    b_rdata    = '0;
    b_err      = 1'b0;
    busy       = 1'b0;

    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = win_fault ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        busy       = 1'b1;
        mem_addr   = cmd_addr;
        if (cmd_we) begin
          mem_write = 1'b1;
          mem_wdata = cmd_wdata;
        end else begin
          mem_read  = 1'b1;
        end
        state_next = RESP;
      end
      RESP: begin
        busy = 1'b1;
        if (cmd_port) begin
          b_ack   = 1'b1;
          b_rdata = resp_data;
          b_err   = cmd_fault;
        end else begin
          a_ack   = 1'b1;
          a_rdata = resp_data;
          a_err   = cmd_fault;
        end
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Command latch, tie-break pointer and response register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= 1'b0;
      cmd_port  <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_fault <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      resp_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            cmd_port  <= win_b;
            cmd_we    <= win_we;
            cmd_addr  <= win_addr;
            cmd_wdata <= win_wdata;
            cmd_fault <= win_fault;
            // Faulted accesses never reach ACCESS, so their response
            // data must already be zero here.
            resp_data <= '0;
            if (tie) begin
              ptr <= ~ptr;
            end
          end
        end
        ACCESS: begin
          resp_data <= cmd_we ? '0 : mem_rdata;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - scoreboard testbench for data_mem_arbiter
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [63:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_ack, a_err, b_ack, b_err;
  logic [63:0] a_rdata, b_rdata;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic        port;
    logic [63:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [63:0] last_rd_addr = '0;
  logic [63:0] last_wr_addr = '0;
  logic [63:0] last_wr_data = '0;

  logic [7:0]  mem [0:63];
  bit          mem_loaded = 1'b0;

  data_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .DEPTH(64)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte-addressed little-endian memory model; byte i preset to i.
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'(i);
      mem_loaded <= 1'b1;
    end else if (mem_write && mem_addr <= 64'd56) begin
      for (int i = 0; i < 8; i++) mem[int'(mem_addr[5:0]) + i] <= mem_wdata[8*i +: 8];
    end
  end

  always_comb begin
    mem_rdata = '0;
    if (mem_addr <= 64'd56) begin
      for (int i = 0; i < 8; i++) mem_rdata[8*i +: 8] = mem[int'(mem_addr[5:0]) + i];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every ack and watches the memory strobes.
  always @(negedge clk) begin
    exp_t e;
    if (mem_read)  begin rd_cnt++; last_rd_addr = mem_addr; end
    if (mem_write) begin wr_cnt++; last_wr_addr = mem_addr; last_wr_data = mem_wdata; end
    check("strobe_exclusive", 64'(mem_read & mem_write), 64'd0);
    if (!mem_read && !mem_write) begin
      check("mem_idle_zero", mem_addr | mem_wdata, 64'd0);
    end
    if (a_ack || b_ack) begin
      check("single_ack", 64'(a_ack & b_ack), 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got a_ack=%0d b_ack=%0d expected none (cycle %0d)", a_ack, b_ack, cyc);
      end else begin
        e = exp_q.pop_front();
        check("ack_port", 64'(b_ack), 64'(e.port));
        check("ack_cycle", 64'(cyc), 64'(e.cyc));
        if (e.port) begin
          check("b_rdata", b_rdata, e.rdata);
          check("b_err", 64'(b_err), 64'(e.err));
          check("a_quiet", a_rdata | 64'(a_err), 64'd0);
        end else begin
          check("a_rdata", a_rdata, e.rdata);
          check("a_err", 64'(a_err), 64'(e.err));
          check("b_quiet", b_rdata | 64'(b_err), 64'd0);
        end
      end
    end else begin
      check("no_ack_quiet", a_rdata | b_rdata | 64'(a_err) | 64'(b_err), 64'd0);
    end
  end

  task automatic drive(input logic port, input logic req, input logic we,
                       input logic [63:0] addr, input logic [63:0] wdata);
    if (port) begin
      b_req = req; b_we = we; b_addr = addr; b_wdata = wdata;
    end else begin
      a_req = req; a_we = we; a_addr = addr; a_wdata = wdata;
    end
  endtask

  // Issues one command and holds req until n_acks acks from that port.
  task automatic run_txn(input logic port, input logic we, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] exp_rdata,
                         input logic exp_err, input int n_acks);
    int start;
    int got;
    int lat;
    exp_t e;
    @(negedge clk);
    start = cyc;
    lat   = exp_err ? 1 : 2;
    for (int k = 0; k < n_acks; k++) begin
      e.port = port; e.rdata = exp_rdata; e.err = exp_err; e.cyc = start + lat + 3 * k;
      exp_q.push_back(e);
    end
    drive(port, 1'b1, we, addr, wdata);
    got = 0;
    for (int t = 0; t < 30 && got < n_acks; t++) begin
      @(negedge clk);
      if ((port ? b_ack : a_ack) === 1'b1) got++;
    end
    drive(port, 1'b0, 1'b0, 64'd0, 64'd0);
    checks++;
    if (got != n_acks) begin
      errors++;
      $display("FAIL txn_timeout: got %0d acks expected %0d (addr 0x%0h)", got, n_acks, addr);
      exp_q.delete();
    end
  endtask

  initial begin
    int rd0, wr0, start, got;
    exp_t e;

    // Both ports request a load of address 0 straight out of reset.
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 64'd0, 64'd0);
    drive(1'b1, 1'b1, 1'b0, 64'd0, 64'd0);
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_acks", 64'(a_ack | b_ack), 64'd0);
    check("reset_strobes", 64'(mem_read | mem_write), 64'd0);

    // Contention: strict alternation A, B, A, B, acks 3 cycles apart.
    rd0   = rd_cnt;
    start = cyc;
    for (int k = 0; k < 4; k++) begin
      e.port = k[0]; e.rdata = 64'h0706050403020100; e.err = 1'b0; e.cyc = start + 2 + 3 * k;
      exp_q.push_back(e);
    end
    reset = 1'b1;
    got = 0;
    for (int t = 0; t < 40 && got < 4; t++) begin
      @(negedge clk);
      if (a_ack || b_ack) got++;
    end
    drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
    check("contention_acks", 64'(got), 64'd4);
    check("contention_reads", 64'(rd_cnt - rd0), 64'd4);

    // Single load of address 8.
    rd0 = rd_cnt; wr0 = wr_cnt;
    run_txn(1'b0, 1'b0, 64'd8, 64'd0, 64'h0F0E0D0C0B0A0908, 1'b0, 1);
    check("load_reads", 64'(rd_cnt - rd0), 64'd1);
    check("load_rd_addr", last_rd_addr, 64'd8);
    check("load_writes", 64'(wr_cnt - wr0), 64'd0);

    // Store then load through port B.
    wr0 = wr_cnt;
    run_txn(1'b1, 1'b1, 64'd16, 64'h1122334455667788, 64'd0, 1'b0, 1);
    check("store_writes", 64'(wr_cnt - wr0), 64'd1);
    check("store_addr", last_wr_addr, 64'd16);
    check("store_data", last_wr_data, 64'h1122334455667788);
    run_txn(1'b1, 1'b0, 64'd16, 64'd0, 64'h1122334455667788, 1'b0, 1);

    // Faults: misaligned, just past the end, and a huge address.
    rd0 = rd_cnt; wr0 = wr_cnt;
    run_txn(1'b0, 1'b0, 64'd3, 64'd0, 64'd0, 1'b1, 1);
    run_txn(1'b0, 1'b0, 64'd64, 64'd0, 64'd0, 1'b1, 1);
    run_txn(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'd0, 1'b1, 1);
    run_txn(1'b1, 1'b1, 64'd60, 64'hDEAD, 64'd0, 1'b1, 1);
    check("fault_reads", 64'(rd_cnt - rd0), 64'd0);
    check("fault_writes", 64'(wr_cnt - wr0), 64'd0);

    // Highest legal address.
    run_txn(1'b0, 1'b0, 64'd56, 64'd0, 64'h3F3E3D3C3B3A3938, 1'b0, 1);

    // Reset during the ACCESS cycle of a store to 24.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 64'd24, 64'hAAAA_BBBB_CCCC_DDDD);
    @(negedge clk);
    check("pre_reset_write", 64'(mem_write), 64'd1);
    #1 reset = 1'b0;
    #1;
    check("reset_write_drop", 64'(mem_write), 64'd0);
    check("reset_busy_drop", 64'(busy), 64'd0);
    check("reset_addr_drop", mem_addr, 64'd0);
    drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    run_txn(1'b0, 1'b0, 64'd24, 64'd0, 64'h1F1E1D1C1B1A1918, 1'b0, 1);

    // req held through the ack cycle gives a second, separate transaction.
    rd0 = rd_cnt;
    run_txn(1'b0, 1'b0, 64'd8, 64'd0, 64'h0F0E0D0C0B0A0908, 1'b0, 2);
    check("held_req_reads", 64'(rd_cnt - rd0), 64'd2);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
